// File: rtl/mastermind_pkg.sv
// Shared types, defaults and helpers for the Mastermind feedback judge.
package mastermind_pkg;

  localparam int unsigned DEF_NUM_PEGS  = 4;
  localparam int unsigned DEF_COLOR_W   = 3;
  localparam int unsigned DEF_MAX_TURNS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXACT,
    COLOR,
    REPORT
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mastermind_judge_if.sv
// Guess/score handshake between the game top level and the judge.
interface mastermind_judge_if
  import mastermind_pkg::*;
#(
  parameter int unsigned NUM_PEGS  = DEF_NUM_PEGS,
  parameter int unsigned COLOR_W   = DEF_COLOR_W,
  parameter int unsigned MAX_TURNS = DEF_MAX_TURNS
);
  localparam int unsigned CNT_W  = clog2(NUM_PEGS + 1);
  localparam int unsigned TURN_W = clog2(MAX_TURNS + 1);

  logic                          new_game;
  logic                          start;
  logic [NUM_PEGS*COLOR_W-1:0]   guess;
  logic [NUM_PEGS*COLOR_W-1:0]   code;
  logic                          busy;
  logic                          done;
  logic [CNT_W-1:0]              exact;
  logic [CNT_W-1:0]              partial;
  logic [TURN_W-1:0]             turn;
  logic                          win;
  logic                          lose;
  logic                          game_over;

  modport master (
    output new_game, start, guess, code,
    input  busy, done, exact, partial, turn, win, lose, game_over
  );

  modport slave (
    input  new_game, start, guess, code,
    output busy, done, exact, partial, turn, win, lose, game_over
  );
endinterface

// File: rtl/mastermind_judge_peg_histogram.sv
// Per-colour occurrence counters with clear, indexed increment and indexed read.
module peg_histogram #(
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned CNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [COLOR_W-1:0] inc_idx_i,
  input  logic [COLOR_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0]   rd_cnt_c_o
);
  localparam int unsigned NUM_COLORS = 1 << COLOR_W;

  logic [CNT_W-1:0] cnt_q [NUM_COLORS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_COLORS; k++) cnt_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < NUM_COLORS; k++) cnt_q[k] <= '0;
    end else if (inc_i) begin
      cnt_q[inc_idx_i] <= cnt_q[inc_idx_i] + CNT_W'(1);
    end
  end

  assign rd_cnt_c_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/mastermind_judge.sv
// Sequential Mastermind scorer: exact pass over pegs, then colour-histogram pass
// for partial matches, plus turn and win/lose bookkeeping.
module mastermind_judge
  import mastermind_pkg::*;
#(
  parameter int unsigned NUM_PEGS  = DEF_NUM_PEGS,
  parameter int unsigned COLOR_W   = DEF_COLOR_W,
  parameter int unsigned MAX_TURNS = DEF_MAX_TURNS
) (
  input logic               clk,
  input logic               reset,
  mastermind_judge_if.slave jif
);
  localparam int unsigned NUM_COLORS = 1 << COLOR_W;
  localparam int unsigned CNT_W      = clog2(NUM_PEGS + 1);
  localparam int unsigned TURN_W     = clog2(MAX_TURNS + 1);
  localparam int unsigned IDX_W      = (NUM_PEGS > 1) ? clog2(NUM_PEGS) : 1;

  state_e             state_q;
  logic [COLOR_W-1:0] g_q [NUM_PEGS];
  logic [COLOR_W-1:0] c_q [NUM_PEGS];
  logic [IDX_W-1:0]   peg_idx_q;
  logic [COLOR_W-1:0] col_idx_q;
  logic [CNT_W-1:0]   exact_acc_q;
  logic [CNT_W-1:0]   partial_acc_q;
  logic [CNT_W-1:0]   exact_q;
  logic [CNT_W-1:0]   partial_q;
  logic [TURN_W-1:0]  turn_q;
  logic               busy_q;
  logic               done_q;
  logic               win_q;
  logic               lose_q;
  logic               game_over_q;

  logic [COLOR_W-1:0] g_peg_c;
  logic [COLOR_W-1:0] c_peg_c;
  logic               peg_match_c;
  logic               hist_clr_c;
  logic               hist_inc_c;
  logic [CNT_W-1:0]   hg_cnt_c;
  logic [CNT_W-1:0]   hc_cnt_c;
  logic [CNT_W-1:0]   min_c;
  logic [TURN_W-1:0]  turn_d;
  logic               win_d;
  logic               lose_d;

  assign g_peg_c     = g_q[peg_idx_q];
  assign c_peg_c     = c_q[peg_idx_q];
  assign peg_match_c = (g_peg_c == c_peg_c);
  assign hist_clr_c  = (state_q == LOAD);
  // Only unmatched pegs feed the histograms, so partials exclude exact hits.
  assign hist_inc_c  = (state_q == EXACT) && !peg_match_c && !jif.new_game;
  assign min_c       = (hg_cnt_c < hc_cnt_c) ? hg_cnt_c : hc_cnt_c;

  assign turn_d = (turn_q == TURN_W'(MAX_TURNS)) ? turn_q : turn_q + TURN_W'(1);
  assign win_d  = (exact_acc_q == CNT_W'(NUM_PEGS));
  assign lose_d = !win_d && (turn_q + TURN_W'(1) == TURN_W'(MAX_TURNS));

  peg_histogram #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_hist_g (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (hist_clr_c),
    .inc_i      (hist_inc_c),
    .inc_idx_i  (g_peg_c),
    .rd_idx_i   (col_idx_q),
    .rd_cnt_c_o (hg_cnt_c)
  );

  peg_histogram #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_hist_c (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (hist_clr_c),
    .inc_i      (hist_inc_c),
    .inc_idx_i  (c_peg_c),
    .rd_idx_i   (col_idx_q),
    .rd_cnt_c_o (hc_cnt_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      for (int p = 0; p < NUM_PEGS; p++) begin
        g_q[p] <= '0;
        c_q[p] <= '0;
      end
      peg_idx_q     <= '0;
      col_idx_q     <= '0;
      exact_acc_q   <= '0;
      partial_acc_q <= '0;
      exact_q       <= '0;
      partial_q     <= '0;
      turn_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (jif.new_game) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        exact_q     <= '0;
        partial_q   <= '0;
        turn_q      <= '0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
        game_over_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (jif.start && !game_over_q) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            for (int p = 0; p < NUM_PEGS; p++) begin
              g_q[p] <= jif.guess[p*COLOR_W +: COLOR_W];
              c_q[p] <= jif.code[p*COLOR_W +: COLOR_W];
            end
            peg_idx_q     <= '0;
            col_idx_q     <= '0;
            exact_acc_q   <= '0;
            partial_acc_q <= '0;
            state_q       <= EXACT;
          end
          EXACT: begin
            if (peg_match_c) exact_acc_q <= exact_acc_q + CNT_W'(1);
            if (peg_idx_q == IDX_W'(NUM_PEGS - 1)) state_q <= COLOR;
            else peg_idx_q <= peg_idx_q + IDX_W'(1);
          end
          COLOR: begin
            partial_acc_q <= partial_acc_q + min_c;
            if (col_idx_q == COLOR_W'(NUM_COLORS - 1)) state_q <= REPORT;
            else col_idx_q <= col_idx_q + COLOR_W'(1);
          end
          REPORT: begin
            done_q      <= 1'b1;
            exact_q     <= exact_acc_q;
            partial_q   <= partial_acc_q;
            turn_q      <= turn_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            game_over_q <= win_d | lose_d;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign jif.busy      = busy_q;
  assign jif.done      = done_q;
  assign jif.exact     = exact_q;
  assign jif.partial   = partial_q;
  assign jif.turn      = turn_q;
  assign jif.win       = win_q;
  assign jif.lose      = lose_q;
  assign jif.game_over = game_over_q;

endmodule

// File: doc/mastermind_judge.md
Name: mastermind_judge

Overview:
Parametrised successor to the fixed 4-peg, 8-colour feedback path of the Mastermind game. It accepts one packed guess and one packed secret code per turn, scores them sequentially and reports exact and partial counts with a done pulse. Scoring counts exact matches (right colour, right position) and partial matches (right colour, wrong position), handling duplicate colours correctly. It also tracks turn count and win/lose state up to a configurable turn limit. It sits between the history/guess path and the seven-segment/turn LED drivers in the mastermind top level.

Parameters:
NUM_PEGS, 4, pegs per code (≥1)
COLOR_W, 3, bits per peg; NUM_COLORS = 2**COLOR_W
MAX_TURNS, 8, turns before loss (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
new_game  in  1  synchronous clear of game state; aborts any scoring in progress
start  in  1  request to score guess against code; sampled in IDLE only
guess  in  NUM_PEGS*COLOR_W  packed guess; peg i = bits [i*COLOR_W +: COLOR_W]
code  in  NUM_PEGS*COLOR_W  packed secret code, same packing
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when exact/partial become valid
exact  out  CNT_W  exact matches; CNT_W = clog2(NUM_PEGS+1)
partial  out  CNT_W  colour-only matches
turn  out  TURN_W  completed turns; TURN_W = clog2(MAX_TURNS+1)
win  out  1  last scored guess had exact == NUM_PEGS
lose  out  1  turn == MAX_TURNS and not win
game_over  out  1  win | lose

Behaviour:
- Reset (async): state IDLE; busy, done, exact, partial, turn, win and lose are all 0; histograms cleared.
- FSM states: IDLE -> LOAD -> EXACT -> COLOR -> REPORT -> IDLE.
- IDLE: if start && !game_over && !new_game, go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - latch guess and code into internal registers; later input changes are ignored;
  - clear the exact accumulator, partial accumulator, peg index and both histograms.
- EXACT (NUM_PEGS cycles, index i = 0..NUM_PEGS-1):
  - if g[i] == c[i], increment exact_acc;
  - else increment hist_g[g[i]] and hist_c[c[i]].
- COLOR (NUM_COLORS cycles, k = 0..NUM_COLORS-1): partial_acc += min(hist_g[k], hist_c[k]).
- REPORT (1 cycle):
  - done = 1; exact and partial load from the accumulators;
  - turn increments (saturating at MAX_TURNS);
  - win = (exact_acc == NUM_PEGS);
  - lose = !win && (turn+1 == MAX_TURNS).
- Latency: the start edge enters LOAD; done is high N + NUM_COLORS + 2 cycles after that edge (14 cycles for the defaults).
- exact and partial hold their values until the next REPORT or new_game.
- start while busy or game_over: ignored, with no queueing.
- new_game:
  - in any state, the next state is IDLE;
  - turn, win, lose, exact and partial clear to 0;
  - done is not asserted.
  - new_game wins over a simultaneous start or REPORT.
- Width rules:
  - histogram entries are CNT_W wide and cannot overflow (each ≤ NUM_PEGS);
  - exact_acc + partial_acc ≤ NUM_PEGS always.
- Counters wrap nowhere. The peg index and colour index are clog2-sized, and the FSM exits on the terminal count.

Decomposition:
- Package mastermind_pkg holds:
  - the state enum (IDLE, LOAD, EXACT, COLOR, REPORT);
  - a clog2 helper function;
  - default localparams for NUM_PEGS, COLOR_W and MAX_TURNS.
- One sub-module, peg_histogram, instantiated twice (guess, code):
  - NUM_COLORS counters with synchronous clear, increment at an index, and read at an index.

Test Plan:
- code {1,2,3,4}, guess {1,2,3,4}, start -> done at cycle 14; exact=4, partial=0, turn=1, win=1, game_over=1.
- code {1,2,3,4}, guess {4,3,2,1} -> exact=0, partial=4, win=0, turn=1.
- Duplicates: code {1,1,2,2}, guess {1,2,1,1} -> exact=1, partial=2; guess {5,5,5,5} -> exact=0, partial=0.
- MAX_TURNS=8 non-winning guesses -> after the 8th done, lose=1 and turn=8; a further start is ignored (busy stays 0, no done).
- start during EXACT, guess changed mid-scoring -> ignored; result reflects the latched guess only.
- new_game at cycle 5 after start -> busy=0 next cycle, no done pulse, turn=0; a following start scores normally.
- Async reset asserted mid-COLOR -> all outputs 0 immediately.
